eth_rx_mm_writer: RTL and testbench
===================================

ETH_RX_MM_WRITER -- requirements
Module: eth_rx_mm_writer

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the target single-port RAM.
REQ-002 Parameter DEPTH, default 4096, RAM depth in 32-bit words; addresses wrap modulo DEPTH.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; arms capture of one packet.
REQ-006 base_addr  in  ADDR_W  first word address; sampled on accepted start.
REQ-007 max_words  in  ADDR_W+1  capacity in words (1..DEPTH); sampled on accepted start.
REQ-008 st_data  in  32  Avalon-ST sink data; first byte in [31:24].
REQ-009 st_valid, st_sop, st_eop  in  1 each  Avalon-ST sink qualifiers.
REQ-010 st_empty  in  2  unused bytes in eop beat, counted from [7:0] upward.
REQ-011 st_ready  out  1  sink ready; zero ready-latency.
REQ-012 m_address  out  ADDR_W  Avalon-MM master word address.
REQ-013 m_chipselect, m_write  out  1 each  master write strobe (both driven identically).
REQ-014 m_byteenable  out  4  bit3 enables [31:24].
REQ-015 m_writedata  out  32  write data.
REQ-016 m_waitrequest  in  1  slave stall; tie 0 for on-chip RAM.
REQ-017 busy  out  1  high from accepted start until done.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 word_count  out  ADDR_W+1  words written for current/last packet.
REQ-020 byte_count  out  ADDR_W+3  bytes written for current/last packet.
REQ-021 overflow, framing_err  out  1 each  sticky status, cleared on accepted start.

Function
REQ-022 FSM states IDLE, WAIT_SOP, XFER, FLUSH, DONE.
REQ-023 IDLE: st_ready=0; start -> WAIT_SOP, latch base/max, clear counts and status; start ignored in any other state.
REQ-024 Beat accepted when st_valid & st_ready; st_ready = (state in WAIT_SOP/XFER/FLUSH) & (!m_write | !m_waitrequest).
REQ-025 WAIT_SOP: non-sop beats accepted and discarded; sop beat is written and -> XFER (or FLUSH/DONE path if also eop).
REQ-026 Accepted written beat at cycle N -> m_write=1 at N+1 with address base_addr+word_count (mod DEPTH), data st_data unmodified.
REQ-027 m_write, m_address, m_writedata, m_byteenable held stable while m_waitrequest=1; write retires on first cycle m_write & !m_waitrequest.
REQ-028 byteenable: non-eop beat 1111; eop beat empty 0/1/2/3 -> 1111/1110/1100/1000.
REQ-029 word_count +1 and byte_count +(4-empty or 4) when write issued, not when retired.
REQ-030 sop in XFER: beat written as data, framing_err set.
REQ-031 Beat accepted with word_count==max_words: discarded, overflow set, state FLUSH; FLUSH discards until eop.
REQ-032 eop beat handled (written or discarded) -> DONE once no write outstanding; DONE asserts done for 1 cycle -> IDLE.
REQ-033 busy=1 in WAIT_SOP/XFER/FLUSH/DONE.
REQ-034 Address arithmetic ADDR_W bits, natural wrap DEPTH-1 -> 0.

Reset
REQ-035 On reset: state IDLE; st_ready, m_write, m_chipselect, busy, done, overflow, framing_err = 0; m_address, m_writedata, word_count, byte_count = 0; m_byteenable = 0000.
REQ-036 Reset mid-transfer abandons pending write immediately (m_write=0 next cycle); no done pulse.

Verification
REQ-037 base=0x010, max=16, 3-beat packet, empty=2 -> writes at 0x010..0x012, last be=1100, word_count=3, byte_count=10, done 1 cycle.
REQ-038 m_waitrequest high 3 cycles on 2nd write -> st_ready low, outputs stable, no data loss, same final memory image.
REQ-039 base=0xFFE, 4-beat packet -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-040 max=2, 5-beat packet -> 2 writes, overflow=1, beats 3-5 accepted and dropped, done after eop.
REQ-041 2 non-sop beats before sop, then sop+eop single beat empty=3 -> 1 write be=1000, byte_count=1; extra sop mid-packet sets framing_err.
REQ-042 reset asserted during XFER with write stalled -> all outputs to reset values next cycle; subsequent start operates normally.

Source files
------------

// File: rtl/eth_rx_mm_writer.sv
// Captures one Avalon-ST packet per start pulse and writes it word by word
// into a single-port RAM through an Avalon-MM write master.
module eth_rx_mm_writer #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   max_words_i,
    input  logic [31:0]       st_data_i,
    input  logic              st_valid_i,
    input  logic              st_sop_i,
    input  logic              st_eop_i,
    input  logic [1:0]        st_empty_i,
    output logic              st_ready_o,
    output logic [ADDR_W-1:0] m_address_o,
    output logic              m_chipselect_o,
    output logic              m_write_o,
    output logic [3:0]        m_byteenable_o,
    output logic [31:0]       m_writedata_o,
    input  logic              m_waitrequest_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [ADDR_W+2:0] byte_count_o,
    output logic              overflow_o,
    output logic              framing_err_o
);

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StWaitSop, StXfer, StFlush, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     max_q, max_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic [ADDR_W+2:0]   byte_count_q, byte_count_d;
    logic                overflow_q, overflow_d;
    logic                framing_err_q, framing_err_d;
    logic                eop_seen_q, eop_seen_d;
    logic                m_write_q, m_write_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic [31:0]         m_writedata_q, m_writedata_d;
    logic [3:0]          m_be_q, m_be_d;

    logic                in_rx;
    logic                st_ready;
    logic                accept;
    logic                full;
    logic                write_beat;
    logic                wr_free;
    logic [ADDR_W:0]     addr_sum;
    logic [2:0]          beat_bytes;
    logic [3:0]          beat_be;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        max_d         = max_q;
        word_count_d  = word_count_q;
        byte_count_d  = byte_count_q;
        overflow_d    = overflow_q;
        framing_err_d = framing_err_q;
        eop_seen_d    = eop_seen_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        m_be_d        = m_be_q;
        write_beat    = 1'b0;

        in_rx    = (state_q == StWaitSop) || (state_q == StXfer) || (state_q == StFlush);
        wr_free  = !m_write_q || !m_waitrequest_i;
        // Once the eop beat is taken, stop accepting until the packet completes.
        st_ready = in_rx && !eop_seen_q && wr_free;
        accept   = st_valid_i && st_ready;
        full     = (word_count_q == max_q);

        addr_sum = {1'b0, base_q} + word_count_q;
        if (addr_sum >= DepthW) begin
            addr_sum = addr_sum - DepthW;
        end

        if (st_eop_i) begin
            beat_bytes = 3'd4 - {1'b0, st_empty_i};
            unique case (st_empty_i)
                2'd0:    beat_be = 4'b1111;
                2'd1:    beat_be = 4'b1110;
                2'd2:    beat_be = 4'b1100;
                default: beat_be = 4'b1000;
            endcase
        end else begin
            beat_bytes = 3'd4;
            beat_be    = 4'b1111;
        end

        if (m_write_q && !m_waitrequest_i) begin
            m_write_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d       = StWaitSop;
                    base_d        = base_addr_i;
                    max_d         = max_words_i;
                    word_count_d  = '0;
                    byte_count_d  = '0;
                    overflow_d    = 1'b0;
                    framing_err_d = 1'b0;
                    eop_seen_d    = 1'b0;
                end
            end
            StWaitSop, StXfer, StFlush: begin
                if (accept) begin
                    if (state_q == StWaitSop) begin
                        if (st_sop_i) begin
                            if (full) begin
                                overflow_d = 1'b1;
                                state_d    = StFlush;
                            end else begin
                                write_beat = 1'b1;
                                state_d    = StXfer;
                            end
                            eop_seen_d = st_eop_i;
                        end
                    end else if (state_q == StXfer) begin
                        if (full) begin
                            overflow_d = 1'b1;
                            state_d    = StFlush;
                        end else begin
                            write_beat = 1'b1;
                            if (st_sop_i) begin
                                framing_err_d = 1'b1;
                            end
                        end
                        eop_seen_d = st_eop_i;
                    end else begin
                        eop_seen_d = st_eop_i;
                    end
                end
                if (eop_seen_q && wr_free) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (write_beat) begin
            m_write_d     = 1'b1;
            m_address_d   = addr_sum[ADDR_W-1:0];
            m_writedata_d = st_data_i;
            m_be_d        = beat_be;
            word_count_d  = word_count_q + 1'b1;
            byte_count_d  = byte_count_q + {{ADDR_W{1'b0}}, beat_bytes};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            base_q        <= '0;
            max_q         <= '0;
            word_count_q  <= '0;
            byte_count_q  <= '0;
            overflow_q    <= 1'b0;
            framing_err_q <= 1'b0;
            eop_seen_q    <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            m_be_q        <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            max_q         <= max_d;
            word_count_q  <= word_count_d;
            byte_count_q  <= byte_count_d;
            overflow_q    <= overflow_d;
            framing_err_q <= framing_err_d;
            eop_seen_q    <= eop_seen_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            m_be_q        <= m_be_d;
        end
    end

    assign st_ready_o     = st_ready;
    assign m_address_o    = m_address_q;
    assign m_chipselect_o = m_write_q;
    assign m_write_o      = m_write_q;
    assign m_byteenable_o = m_be_q;
    assign m_writedata_o  = m_writedata_q;
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign word_count_o   = word_count_q;
    assign byte_count_o   = byte_count_q;
    assign overflow_o     = overflow_q;
    assign framing_err_o  = framing_err_q;

endmodule

// File: tb/tb_eth_rx_mm_writer.sv
// Directed bench for eth_rx_mm_writer: RAM model fed by retired writes,
// waitrequest stall injection and hand-computed expected images.
module tb_eth_rx_mm_writer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [11:0] base_addr_i = '0;
    logic [12:0] max_words_i = '0;
    logic [31:0] st_data_i = '0;
    logic        st_valid_i = 1'b0;
    logic        st_sop_i = 1'b0;
    logic        st_eop_i = 1'b0;
    logic [1:0]  st_empty_i = '0;
    logic        st_ready_o;
    logic [11:0] m_address_o;
    logic        m_chipselect_o;
    logic        m_write_o;
    logic [3:0]  m_byteenable_o;
    logic [31:0] m_writedata_o;
    logic        m_waitrequest_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [12:0] word_count_o;
    logic [14:0] byte_count_o;
    logic        overflow_o;
    logic        framing_err_o;

    eth_rx_mm_writer #(.ADDR_W(12), .DEPTH(4096)) u_dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .max_words_i    (max_words_i),
        .st_data_i      (st_data_i),
        .st_valid_i     (st_valid_i),
        .st_sop_i       (st_sop_i),
        .st_eop_i       (st_eop_i),
        .st_empty_i     (st_empty_i),
        .st_ready_o     (st_ready_o),
        .m_address_o    (m_address_o),
        .m_chipselect_o (m_chipselect_o),
        .m_write_o      (m_write_o),
        .m_byteenable_o (m_byteenable_o),
        .m_writedata_o  (m_writedata_o),
        .m_waitrequest_i(m_waitrequest_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .word_count_o   (word_count_o),
        .byte_count_o   (byte_count_o),
        .overflow_o     (overflow_o),
        .framing_err_o  (framing_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // RAM model and write monitor
    bit   [31:0] mem [4096];
    bit   [11:0] log_addr [256];
    bit   [3:0]  last_be;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          stall_seen = 0;
    int          stab_bad = 0;
    int          rdy_bad = 0;
    bit          prev_stall = 1'b0;
    bit   [11:0] sv_addr;
    bit   [31:0] sv_data;
    bit   [3:0]  sv_be;

    always @(posedge clk_i) begin
        if (m_write_o && !m_waitrequest_i) begin
            for (int b = 0; b < 4; b++) begin
                if (m_byteenable_o[b]) mem[m_address_o][8*b +: 8] <= m_writedata_o[8*b +: 8];
            end
            log_addr[wr_cnt[7:0]] <= m_address_o;
            last_be <= m_byteenable_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (done_o) done_cnt <= done_cnt + 1;
        if (m_write_o && m_waitrequest_i) stall_seen <= stall_seen + 1;
        if (prev_stall && (!m_write_o || m_address_o != sv_addr || m_writedata_o != sv_data ||
                           m_byteenable_o != sv_be)) stab_bad <= stab_bad + 1;
        if (m_waitrequest_i && m_write_o && st_ready_o) rdy_bad <= rdy_bad + 1;
        prev_stall <= m_write_o && m_waitrequest_i && !reset_i;
        sv_addr <= m_address_o;
        sv_data <= m_writedata_o;
        sv_be <= m_byteenable_o;
    end

    // Stall injection: write number stall_idx (1-based, absolute) sees stall_len wait cycles
    int stall_idx = 0;
    int stall_len = 0;
    int stall_cnt = 0;

    always @(negedge clk_i) begin
        if (m_write_o && (wr_cnt + 1 == stall_idx) && (stall_cnt < stall_len)) begin
            m_waitrequest_i <= 1'b1;
            stall_cnt <= stall_cnt + 1;
        end else begin
            m_waitrequest_i <= 1'b0;
            if (!(m_write_o && (wr_cnt + 1 == stall_idx))) stall_cnt <= 0;
        end
    end

    task automatic do_start(input logic [11:0] base, input logic [12:0] maxw);
        base_addr_i = base;
        max_words_i = maxw;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] e);
        int n;
        st_data_i = d;
        st_sop_i = sop;
        st_eop_i = eop;
        st_empty_i = e;
        st_valid_i = 1'b1;
        n = 0;
        #1;
        while (!st_ready_o && n < 100) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("beat_accepted", 32'(st_ready_o), 32'd1);
        @(negedge clk_i);
        st_valid_i = 1'b0;
        st_sop_i = 1'b0;
        st_eop_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("done_seen", 32'(done_o), 32'd1);
        @(negedge clk_i);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("busy_after_done", 32'(busy_o), 32'd0);
    endtask

    int w0, d0, s0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        check("rst_st_ready", 32'(st_ready_o), 32'd0);
        check("rst_m_write", 32'(m_write_o), 32'd0);
        check("rst_chipselect", 32'(m_chipselect_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_addr", 32'(m_address_o), 32'd0);
        check("rst_be", 32'(m_byteenable_o), 32'd0);
        check("rst_wdata", m_writedata_o, 32'd0);
        check("rst_wcnt", 32'(word_count_o), 32'd0);
        check("rst_bcnt", 32'(byte_count_o), 32'd0);
        check("rst_flags", 32'({overflow_o, framing_err_o}), 32'd0);

        // Basic 3-beat packet, last beat empty=2
        w0 = wr_cnt; d0 = done_cnt;
        do_start(12'h010, 13'd16);
        check("t1_busy", 32'(busy_o), 32'd1);
        send_beat(32'hA0A1A2A3, 1'b1, 1'b0, 2'd0);
        send_beat(32'hB0B1B2B3, 1'b0, 1'b0, 2'd0);
        send_beat(32'hC0C1C2C3, 1'b0, 1'b1, 2'd2);
        wait_done();
        check("t1_writes", 32'(wr_cnt - w0), 32'd3);
        check("t1_addr0", 32'(log_addr[w0]), 32'h010);
        check("t1_addr2", 32'(log_addr[w0 + 2]), 32'h012);
        check("t1_mem0", mem[12'h010], 32'hA0A1A2A3);
        check("t1_mem1", mem[12'h011], 32'hB0B1B2B3);
        check("t1_mem2", mem[12'h012], 32'hC0C10000);
        check("t1_last_be", 32'(last_be), 32'b1100);
        check("t1_wcnt", 32'(word_count_o), 32'd3);
        check("t1_bcnt", 32'(byte_count_o), 32'd10);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Same packet with the 2nd write stalled for 3 cycles
        w0 = wr_cnt; s0 = stall_seen;
        stall_idx = wr_cnt + 2;
        stall_len = 3;
        do_start(12'h020, 13'd16);
        send_beat(32'hA0A1A2A3, 1'b1, 1'b0, 2'd0);
        send_beat(32'hB0B1B2B3, 1'b0, 1'b0, 2'd0);
        send_beat(32'hC0C1C2C3, 1'b0, 1'b1, 2'd2);
        wait_done();
        stall_idx = 0;
        check("t2_stall_cycles", 32'(stall_seen - s0), 32'd3);
        check("t2_writes", 32'(wr_cnt - w0), 32'd3);
        check("t2_mem0", mem[12'h020], 32'hA0A1A2A3);
        check("t2_mem1", mem[12'h021], 32'hB0B1B2B3);
        check("t2_mem2", mem[12'h022], 32'hC0C10000);
        check("t2_bcnt", 32'(byte_count_o), 32'd10);
        check("t2_stable", 32'(stab_bad), 32'd0);
        check("t2_ready_low", 32'(rdy_bad), 32'd0);

        // Address wrap from 0xFFE
        w0 = wr_cnt;
        do_start(12'hFFE, 13'd16);
        send_beat(32'h00000001, 1'b1, 1'b0, 2'd0);
        send_beat(32'h00000002, 1'b0, 1'b0, 2'd0);
        send_beat(32'h00000003, 1'b0, 1'b0, 2'd0);
        send_beat(32'h00000004, 1'b0, 1'b1, 2'd0);
        wait_done();
        check("t3_addr0", 32'(log_addr[w0]), 32'hFFE);
        check("t3_addr1", 32'(log_addr[w0 + 1]), 32'hFFF);
        check("t3_addr2", 32'(log_addr[w0 + 2]), 32'h000);
        check("t3_addr3", 32'(log_addr[w0 + 3]), 32'h001);
        check("t3_mem_wrap", mem[12'h001], 32'h00000004);
        check("t3_bcnt", 32'(byte_count_o), 32'd16);

        // Overflow: max=2, 5-beat packet
        w0 = wr_cnt; d0 = done_cnt;
        do_start(12'h030, 13'd2);
        for (int i = 0; i < 5; i++) begin
            send_beat(32'h5000_0000 + 32'(i), (i == 0), (i == 4), 2'd0);
        end
        wait_done();
        check("t4_writes", 32'(wr_cnt - w0), 32'd2);
        check("t4_overflow", 32'(overflow_o), 32'd1);
        check("t4_wcnt", 32'(word_count_o), 32'd2);
        check("t4_bcnt", 32'(byte_count_o), 32'd8);
        check("t4_mem_untouched", mem[12'h032], 32'd0);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Junk before sop, then single sop+eop beat with empty=3
        w0 = wr_cnt;
        do_start(12'h040, 13'd16);
        check("t5_overflow_cleared", 32'(overflow_o), 32'd0);
        send_beat(32'hDEAD0001, 1'b0, 1'b0, 2'd0);
        send_beat(32'hDEAD0002, 1'b0, 1'b0, 2'd0);
        send_beat(32'h11223344, 1'b1, 1'b1, 2'd3);
        wait_done();
        check("t5_writes", 32'(wr_cnt - w0), 32'd1);
        check("t5_be", 32'(last_be), 32'b1000);
        check("t5_mem", mem[12'h040], 32'h11000000);
        check("t5_bcnt", 32'(byte_count_o), 32'd1);
        check("t5_framing_clear", 32'(framing_err_o), 32'd0);
        // Extra sop mid-packet
        do_start(12'h048, 13'd16);
        send_beat(32'hE1E1E1E1, 1'b1, 1'b0, 2'd0);
        send_beat(32'hE2E2E2E2, 1'b1, 1'b0, 2'd0);
        send_beat(32'hE3E3E3E3, 1'b0, 1'b1, 2'd0);
        wait_done();
        check("t5_framing_err", 32'(framing_err_o), 32'd1);
        check("t5_sop_written", mem[12'h049], 32'hE2E2E2E2);
        check("t5_wcnt", 32'(word_count_o), 32'd3);

        // Reset while a write is stalled in XFER
        w0 = wr_cnt; d0 = done_cnt;
        stall_idx = wr_cnt + 1;
        stall_len = 1000;
        do_start(12'h050, 13'd16);
        send_beat(32'hF1F1F1F1, 1'b1, 1'b0, 2'd0);
        repeat (3) @(negedge clk_i);
        check("t6_stalled_write", 32'(m_write_o), 32'd1);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("t6_m_write", 32'(m_write_o), 32'd0);
        check("t6_chipselect", 32'(m_chipselect_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_st_ready", 32'(st_ready_o), 32'd0);
        check("t6_addr", 32'(m_address_o), 32'd0);
        check("t6_wdata", m_writedata_o, 32'd0);
        check("t6_be", 32'(m_byteenable_o), 32'd0);
        check("t6_wcnt", 32'(word_count_o), 32'd0);
        check("t6_bcnt", 32'(byte_count_o), 32'd0);
        stall_idx = 0;
        reset_i = 1'b0;
        @(negedge clk_i);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check("t6_no_retire", 32'(wr_cnt - w0), 32'd0);
        do_start(12'h060, 13'd16);
        send_beat(32'h12345678, 1'b1, 1'b0, 2'd0);
        send_beat(32'h9ABCDEF0, 1'b0, 1'b1, 2'd1);
        wait_done();
        check("t6_after_mem0", mem[12'h060], 32'h12345678);
        check("t6_after_mem1", mem[12'h061], 32'h9ABCDE00);
        check("t6_after_bcnt", 32'(byte_count_o), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
